// File: rtl/tr5_led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: register map, CTRL/STATUS
// bit positions, FSM state type and default widths.
package tr5_led_seq_pkg;

    localparam int unsigned DEF_LED_W   = 4;
    localparam int unsigned DEF_PRESC_W = 24;
    localparam int unsigned DEF_DEPTH   = 8;

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_PRESCALE = 4'd1;
    localparam logic [3:0] ADDR_LENGTH   = 4'd2;
    localparam logic [3:0] ADDR_STATUS   = 4'd3;
    localparam logic [3:0] ADDR_MANUAL   = 4'd4;

    localparam int unsigned CTRL_RUN_BIT    = 0;
    localparam int unsigned CTRL_LOOP_BIT   = 1;
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_IDX_LSB  = 4;
    localparam int unsigned STATUS_DONE_BIT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/tr5_led_step_timer.sv
// Loadable down-counter that paces pattern steps; tick marks the last cycle
// of a step (count has reached zero while enabled).
module tr5_led_step_timer #(
    parameter int unsigned PRESC_W = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               en,
    input  logic [PRESC_W-1:0] load_value,
    output logic               tick
);

    logic [PRESC_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - PRESC_W'(1);
        end
    end

    assign tick = en && (count == '0);

endmodule

// File: rtl/tr5_led_sequencer.sv
// Avalon-MM LED sequencer: plays a software-loaded pattern table at a
// programmable step rate, with a static manual value shown while idle.
module tr5_led_sequencer
    import tr5_led_seq_pkg::*;
#(
    parameter int unsigned LED_W   = DEF_LED_W,
    parameter int unsigned PRESC_W = DEF_PRESC_W,
    parameter int unsigned DEPTH   = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [LED_W-1:0] out_port
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    seq_state_t         state, state_d;
    logic               ctrl_run, ctrl_loop, run_d, loop_d;
    logic               done, done_d;
    logic [PRESC_W-1:0] prescale;
    logic [IDX_W-1:0]   length;
    logic [IDX_W-1:0]   index, index_d;
    logic [LED_W-1:0]   manual;
    logic [LED_W-1:0]   pattern [DEPTH];
    logic [LED_W-1:0]   out_d, pat_d, man_d;
    logic               load, tick;

    logic             wr, wr_ctrl, wr_presc, wr_len, wr_status, wr_manual, wr_pat;
    logic             pat_valid, done_clr;
    logic [IDX_W-1:0] pat_idx;
    logic             unused_wdata;

    assign wr        = chipselect && !write_n;
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign wr_presc  = wr && (address == ADDR_PRESCALE);
    assign wr_len    = wr && (address == ADDR_LENGTH);
    assign wr_status = wr && (address == ADDR_STATUS);
    assign wr_manual = wr && (address == ADDR_MANUAL);
    assign pat_valid = address[3] && (32'(address[2:0]) < DEPTH);
    assign pat_idx   = IDX_W'(address[2:0]);
    assign wr_pat    = wr && pat_valid;
    assign done_clr  = wr_status && writedata[STATUS_DONE_BIT];
    assign unused_wdata = ^writedata;

    tr5_led_step_timer #(.PRESC_W(PRESC_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .en         (state == RUN),
        .load_value (prescale),
        .tick       (tick)
    );

    always_comb begin
        state_d = state;
        index_d = index;
        run_d   = ctrl_run;
        loop_d  = ctrl_loop;
        done_d  = done_clr ? 1'b0 : done;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_ctrl) begin
                    run_d  = writedata[CTRL_RUN_BIT];
                    loop_d = writedata[CTRL_LOOP_BIT];
                    if (writedata[CTRL_RUN_BIT]) begin
                        state_d = RUN;
                        index_d = '0;
                        load    = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    if (index < length) begin
                        index_d = index + IDX_W'(1);
                        load    = 1'b1;
                    end else if (ctrl_loop) begin
                        index_d = '0;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        run_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                // A CTRL write overrides whatever the step boundary decided,
                // including suppressing the DONE it would have set.
                if (wr_ctrl) begin
                    run_d  = writedata[CTRL_RUN_BIT];
                    loop_d = writedata[CTRL_LOOP_BIT];
                    if (!writedata[CTRL_RUN_BIT]) begin
                        state_d = IDLE;
                        done_d  = done_clr ? 1'b0 : done;
                    end else if (state_d == IDLE) begin
                        state_d = RUN;
                        index_d = '0;
                        load    = 1'b1;
                        done_d  = done_clr ? 1'b0 : done;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // out_port is registered, so it is built from next-cycle values
        pat_d = pattern[index_d];
        if (wr_pat && (pat_idx == index_d)) begin
            pat_d = writedata[LED_W-1:0];
        end
        man_d = wr_manual ? writedata[LED_W-1:0] : manual;
        out_d = (state_d == RUN) ? pat_d : man_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            index     <= '0;
            ctrl_run  <= 1'b0;
            ctrl_loop <= 1'b0;
            done      <= 1'b0;
            prescale  <= '0;
            length    <= '0;
            manual    <= '0;
            out_port  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pattern[i] <= '0;
            end
        end else begin
            state     <= state_d;
            index     <= index_d;
            ctrl_run  <= run_d;
            ctrl_loop <= loop_d;
            done      <= done_d;
            out_port  <= out_d;
            if (wr_presc)  prescale <= writedata[PRESC_W-1:0];
            if (wr_len)    length   <= writedata[IDX_W-1:0];
            if (wr_manual) manual   <= writedata[LED_W-1:0];
            if (wr_pat)    pattern[pat_idx] <= writedata[LED_W-1:0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_RUN_BIT]  = ctrl_run;
                readdata[CTRL_LOOP_BIT] = ctrl_loop;
            end
            ADDR_PRESCALE: readdata[PRESC_W-1:0] = prescale;
            ADDR_LENGTH:   readdata[IDX_W-1:0]   = length;
            ADDR_STATUS: begin
                readdata[STATUS_BUSY_BIT]               = (state == RUN);
                readdata[STATUS_IDX_LSB +: IDX_W]       = index;
                readdata[STATUS_DONE_BIT]               = done;
            end
            ADDR_MANUAL:   readdata[LED_W-1:0] = manual;
            default: begin
                if (pat_valid) readdata[LED_W-1:0] = pattern[pat_idx];
            end
        endcase
    end

endmodule

// File: tb/tb_tr5_led_sequencer.sv
// Directed self-checking bench for tr5_led_sequencer with hand-computed
// expected LED and register values.
module tb_tr5_led_sequencer;

    logic        clk;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int unsigned checks = 0;
    int unsigned errors = 0;

    tr5_led_sequencer #(.LED_W(4), .PRESC_W(24), .DEPTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge: the write is captured at the next posedge and the
    // task returns at the following negedge, when its effects are visible.
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        for (int a = 0; a < 16; a++) begin
            bus_rd(4'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", a, d, 32'h0);
            end
        end
        checks++;
        if (out_port !== 4'h0) begin
            errors++;
            $display("FAIL reset_out got=%h exp=%h", out_port, 4'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_manual;
        logic [31:0] d;
        bus_wr(4'd4, 32'h0000_000A);
        checks++;
        if (out_port !== 4'hA) begin
            errors++;
            $display("FAIL manual_out got=%h exp=%h", out_port, 4'hA);
        end
        bus_wr(4'd8, 32'h0000_0001);
        checks++;
        if (out_port !== 4'hA) begin
            errors++;
            $display("FAIL pattern_write_idle got=%h exp=%h", out_port, 4'hA);
        end
        bus_rd(4'd8, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL pattern0_readback got=%h exp=%h", d, 32'h1);
        end
        bus_wr(4'd5, 32'h0000_00FF);
        bus_rd(4'd5, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got=%h exp=%h", d, 32'h0);
        end
        bus_wr(4'd1, 32'hFFFF_FFFF);
        bus_rd(4'd1, d);
        checks++;
        if (d !== 32'h00FF_FFFF) begin
            errors++;
            $display("FAIL prescale_width got=%h exp=%h", d, 32'h00FF_FFFF);
        end
        @(negedge clk);
    endtask

    task automatic test_single_run;
        logic [3:0]  pat [4];
        logic [31:0] d;
        pat[0] = 4'h1; pat[1] = 4'h2; pat[2] = 4'h4; pat[3] = 4'h8;
        bus_wr(4'd9,  32'h2);
        bus_wr(4'd10, 32'h4);
        bus_wr(4'd11, 32'h8);
        bus_wr(4'd2,  32'h3);
        bus_wr(4'd1,  32'h2);
        bus_wr(4'd0,  32'h1);
        bus_rd(4'd3, d);
        checks++;
        if (d !== 32'h001) begin
            errors++;
            $display("FAIL run_status_start got=%h exp=%h", d, 32'h001);
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (out_port !== pat[s]) begin
                    errors++;
                    $display("FAIL single_step s=%0d c=%0d got=%h exp=%h", s, c, out_port, pat[s]);
                end
                @(negedge clk);
            end
        end
        checks++;
        if (out_port !== 4'hA) begin
            errors++;
            $display("FAIL single_end_manual got=%h exp=%h", out_port, 4'hA);
        end
        bus_rd(4'd3, d);
        checks++;
        if (d !== 32'h130) begin
            errors++;
            $display("FAIL single_status got=%h exp=%h", d, 32'h130);
        end
        bus_rd(4'd0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL single_ctrl_selfclear got=%h exp=%h", d, 32'h0);
        end
        bus_wr(4'd3, 32'h100);
        bus_rd(4'd3, d);
        checks++;
        if (d[8] !== 1'b0) begin
            errors++;
            $display("FAIL done_clear got=%b exp=%b", d[8], 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic test_loop;
        logic [3:0]  pat [4];
        logic [31:0] d;
        pat[0] = 4'h1; pat[1] = 4'h2; pat[2] = 4'h4; pat[3] = 4'h8;
        bus_wr(4'd1, 32'h0);
        bus_wr(4'd0, 32'h3);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (out_port !== pat[k % 4]) begin
                errors++;
                $display("FAIL loop_step k=%0d got=%h exp=%h", k, out_port, pat[k % 4]);
            end
            @(negedge clk);
        end
        bus_wr(4'd0, 32'h2);
        checks++;
        if (out_port !== 4'hA) begin
            errors++;
            $display("FAIL loop_stop_manual got=%h exp=%h", out_port, 4'hA);
        end
        bus_rd(4'd3, d);
        checks++;
        if ((d & 32'h101) !== 32'h0) begin
            errors++;
            $display("FAIL loop_stop_status got=%h exp_busy_done=%h", d & 32'h101, 32'h0);
        end
        bus_rd(4'd0, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL loop_stop_ctrl got=%h exp=%h", d, 32'h2);
        end
        @(negedge clk);
    endtask

    task automatic test_live_update;
        logic [31:0] d;
        bus_wr(4'd1, 32'h2);
        bus_wr(4'd0, 32'h1);
        repeat (6) @(negedge clk);
        checks++;
        if (out_port !== 4'h4) begin
            errors++;
            $display("FAIL live_index2 got=%h exp=%h", out_port, 4'h4);
        end
        bus_wr(4'd10, 32'hF);
        checks++;
        if (out_port !== 4'hF) begin
            errors++;
            $display("FAIL live_pattern_current got=%h exp=%h", out_port, 4'hF);
        end
        bus_wr(4'd2, 32'h1);
        checks++;
        if (out_port !== 4'hF) begin
            errors++;
            $display("FAIL live_len_step_last got=%h exp=%h", out_port, 4'hF);
        end
        @(negedge clk);
        checks++;
        if (out_port !== 4'hA) begin
            errors++;
            $display("FAIL live_len_end got=%h exp=%h", out_port, 4'hA);
        end
        bus_rd(4'd3, d);
        checks++;
        if (d !== 32'h120) begin
            errors++;
            $display("FAIL live_len_status got=%h exp=%h", d, 32'h120);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        bus_wr(4'd2, 32'h3);
        bus_wr(4'd0, 32'h1);
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== 4'h0) begin
            errors++;
            $display("FAIL async_reset_out got=%h exp=%h", out_port, 4'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(4'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_status got=%h exp=%h", d, 32'h0);
        end
        bus_rd(4'd10, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_pattern got=%h exp=%h", d, 32'h0);
        end
        @(negedge clk);
        bus_wr(4'd8, 32'h5);
        bus_wr(4'd0, 32'h1);
        checks++;
        if (out_port !== 4'h5) begin
            errors++;
            $display("FAIL restart_out got=%h exp=%h", out_port, 4'h5);
        end
        bus_rd(4'd3, d);
        checks++;
        if (d !== 32'h001) begin
            errors++;
            $display("FAIL restart_status got=%h exp=%h", d, 32'h001);
        end
        @(negedge clk);
        checks++;
        if (out_port !== 4'h0) begin
            errors++;
            $display("FAIL restart_end got=%h exp=%h", out_port, 4'h0);
        end
        bus_rd(4'd3, d);
        checks++;
        if (d !== 32'h100) begin
            errors++;
            $display("FAIL restart_done got=%h exp=%h", d, 32'h100);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_manual();
        test_single_run();
        test_loop();
        test_live_update();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tr5_led_sequencer.md
# tr5_led_sequencer

Avalon-MM slave controller that sequences the board LEDs through a software-loaded table of up to eight patterns at a programmable step rate. It replaces direct PIO writes to the LEDs with hardware-timed playback, and keeps a manual override for static values. It sits on the Qsys system interconnect beside the other PIO slaves and drives the top-level LED pins.

## Interface
- `LED_W`, default 4: LED output width.
- `PRESC_W`, default 24: step prescaler width.
- `DEPTH`, default 8: pattern table entries (power of two).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `address`  in  4  word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, combinational from `address`, zero-extended.
- `out_port`  out  LED_W  LED drive, registered.

## Operation
- Register map (write when `chipselect && !write_n`):
  - 0 CTRL: bit0 RUN, bit1 LOOP. RUN self-clears at end of a non-loop sequence.
  - 1 PRESCALE: [PRESC_W-1:0]. Step length is PRESCALE+1 cycles.
  - 2 LENGTH: [2:0] = steps-1, so 0 means 1 step.
  - 3 STATUS: read bit0 BUSY, [6:4] current step index, bit8 DONE (sticky). Writing 1 to bit8 clears DONE.
  - 4 MANUAL: [LED_W-1:0], driven on `out_port` while IDLE.
  - 8..15 PATTERN[0..7]: [LED_W-1:0] each.
  - Unmapped addresses read 0 and ignore writes.
- States:
  - IDLE: `out_port` = MANUAL. A RUN 0→1 write moves to RUN, sets index 0, loads the counter with PRESCALE, and clears DONE.
  - RUN: `out_port` = PATTERN[index]. The counter decrements each cycle. At 0:
    - if index < LENGTH: index+1, reload counter.
    - else if LOOP: index←0, reload counter.
    - else: go to IDLE, clear RUN, set DONE.
- A RUN=0 write during RUN forces IDLE next cycle. DONE is not set.
- A RUN=1 write during RUN (RUN already 1) is ignored; the sequence does not restart.
- A PATTERN write during RUN: entries take effect whenever they are next displayed, including immediately if it is the current index.
- PRESCALE and LENGTH writes during RUN apply at the next counter reload or index comparison.
- LENGTH is compared against the live value. If LENGTH is lowered below the current index, the sequence ends (or wraps) at the next step boundary.
- If hardware end-of-sequence coincides with a software write to CTRL, the software write wins.
- If hardware DONE-set coincides with a software DONE-clear, set wins.

## Timing
- Reset: all registers 0, state IDLE, `out_port` = 0, index 0, counter 0, `readdata` reflects zeroed registers.
- A write in cycle N is visible on `readdata` and affects state from N+1. Reads have zero wait states.
- RUN write at N: `out_port` = PATTERN[0] from N+1. Each step lasts exactly PRESCALE+1 cycles.
- A non-loop sequence returns `out_port` to MANUAL exactly (LENGTH+1)·(PRESCALE+1) cycles after N+1.
- A MANUAL write in IDLE at N: `out_port` updates at N+1.
- Asserting `reset_n` mid-run returns to IDLE and `out_port` = 0 asynchronously.

## Structure
- Package `tr5_led_seq_pkg`:
  - register address constants
  - CTRL/STATUS bit positions
  - state enum {IDLE, RUN}
  - default widths
- Sub-module `tr5_led_step_timer`: loadable PRESC_W down-counter with `load`, `en`, `tick` (tick when count==0 and en).
- The top level holds the register file, table, index counter, FSM and read mux.

## Test plan
- Reset then read all addresses: readdata=0 everywhere, out_port=0.
- MANUAL=0xA in IDLE: out_port=0xA one cycle after the write. A PATTERN write does not change out_port.
- PATTERN={1,2,4,8}, LENGTH=3, PRESCALE=2, LOOP=0, RUN=1:
  - out_port shows 1,2,4,8 for 3 cycles each, then MANUAL.
  - STATUS reads DONE=1, BUSY=0, CTRL.RUN=0.
- Same sequence with LOOP=1 and PRESCALE=0:
  - pattern changes every cycle and wraps 8→1.
  - writing RUN=0 mid-step gives MANUAL next cycle, DONE=0.
- During RUN at index 2:
  - write LENGTH=1: sequence ends at the next step boundary.
  - overwrite PATTERN[current] with 0xF: out_port=0xF next cycle.
- Assert `reset_n` mid-run, then release: out_port=0, STATUS=0, a new RUN starts at index 0.
